// File: rtl/ica_pkg.sv
// Shared types and arithmetic helpers for the ICA covariance stage.
package ica_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    WRITE,
    DONE
  } cov_state_t;

  function automatic int acc_width(input int n_bits, input int size_b);
    return 2 * n_bits + $clog2(size_b);
  endfunction

  // Clamp a sign-extended value into an n-bit signed range.
  function automatic logic [127:0] sat_narrow(
    input logic signed [127:0] v,
    input int                  n
  );
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    hi = (128'sd1 <<< (n - 1)) - 128'sd1;
    lo = -hi - 128'sd1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/cov_mac.sv
// Time-shared MAC: combinational signed product into a registered
// accumulator with synchronous clear and enable.
module cov_mac
  import ica_pkg::*;
#(
  parameter int N_BITS = 22,
  parameter int AW     = acc_width(22, 8)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [N_BITS-1:0] a,
  input  logic signed [N_BITS-1:0] b,
  output logic signed [AW-1:0]     acc
);

  logic signed [2*N_BITS-1:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + AW'(prod);
    end
  end

endmodule

// File: rtl/covariance_seq.sv
// Sequential covariance C = X*X^T / SIZE_B over the upper triangle.
// Define COV_SATURATE_EN to clamp results instead of wrapping.
module covariance_seq
  import ica_pkg::*;
#(
  parameter int SIZE_A    = 8,
  parameter int SIZE_B    = 8,
  parameter int N_BITS    = 22,
  parameter int FRAC_BITS = 0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [SIZE_A-1:0][SIZE_B-1:0][N_BITS-1:0] matrix,
  output logic                                  busy,
  output logic                                  done,
  output logic [SIZE_A-1:0][SIZE_A-1:0][N_BITS-1:0] cov
);

  localparam int AW = acc_width(N_BITS, SIZE_B);
  localparam int SH = FRAC_BITS + $clog2(SIZE_B);
  localparam int IW = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
  localparam int KW = $clog2(SIZE_B);

  localparam logic [IW-1:0] I_LAST = IW'(SIZE_A - 1);
  localparam logic [KW-1:0] K_LAST = KW'(SIZE_B - 1);

  cov_state_t state, nxt;

  logic [IW-1:0] i, j;
  logic [KW-1:0] k;
  logic [SIZE_A-1:0][SIZE_B-1:0][N_BITS-1:0] x_q;

  logic signed [AW-1:0]     acc;
  logic                     mac_clr;
  logic                     mac_en;
  logic [N_BITS-1:0]        r;
  logic                     last_pair;

  assign last_pair = (i == I_LAST) && (j == I_LAST);
  assign mac_clr   = ((state == IDLE) && start) || (state == WRITE);
  assign mac_en    = (state == ACC);
  assign busy      = (state == ACC) || (state == WRITE);
  assign done      = (state == DONE);

`ifdef COV_SATURATE_EN
  assign r = N_BITS'(sat_narrow(128'(acc >>> SH), N_BITS));
`else
  assign r = N_BITS'(acc >>> SH);
`endif

  cov_mac #(
    .N_BITS (N_BITS),
    .AW     (AW)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clear (mac_clr),
    .en    (mac_en),
    .a     (x_q[i][k]),
    .b     (x_q[j][k]),
    .acc   (acc)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (start) nxt = ACC;
      ACC:   if (k == K_LAST) nxt = WRITE;
      WRITE: nxt = last_pair ? DONE : ACC;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      x_q   <= '0;
      cov   <= '0;
    end else begin
      state <= nxt;
      unique case (state)
        IDLE: begin
          if (start) begin
            x_q <= matrix;
            i   <= '0;
            j   <= '0;
            k   <= '0;
          end
        end
        ACC: begin
          k <= (k == K_LAST) ? '0 : k + 1'b1;
        end
        WRITE: begin
          cov[i][j] <= r;
          cov[j][i] <= r;
          k <= '0;
          // New row restarts on its diagonal element.
          if (j == I_LAST) begin
            i <= i + 1'b1;
            j <= i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_covariance_seq.sv
// Scoreboard bench for covariance_seq (8x8, 22-bit, FRAC_BITS=0).
module tb_covariance_seq;

  localparam int A = 8;
  localparam int B = 8;
  localparam int N = 22;

  typedef logic [A-1:0][B-1:0][N-1:0] mat_t;

  logic clk;
  logic reset;
  logic start;
  mat_t matrix;
  logic busy;
  logic done;
  logic [A-1:0][A-1:0][N-1:0] cov;

  int errors = 0;
  int checks = 0;
  logic [N-1:0] exp_q[$];

  covariance_seq #(
    .SIZE_A    (A),
    .SIZE_B    (B),
    .N_BITS    (N),
    .FRAC_BITS (0)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .matrix (matrix),
    .busy   (busy),
    .done   (done),
    .cov    (cov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] golden(input longint s);
    longint q;
    q = s >>> 3;
`ifdef COV_SATURATE_EN
    if (q > longint'((1 << (N - 1)) - 1)) q = (1 << (N - 1)) - 1;
    if (q < -longint'(1 << (N - 1)))      q = -(1 << (N - 1));
`endif
    return q[N-1:0];
  endfunction

  task automatic push_expected(input mat_t m);
    longint s;
    for (int i = 0; i < A; i++) begin
      for (int j = 0; j < A; j++) begin
        s = 0;
        for (int k = 0; k < B; k++)
          s += longint'($signed(m[i][k])) * longint'($signed(m[j][k]));
        exp_q.push_back(golden(s));
      end
    end
  endtask

  function automatic mat_t rand_mat();
    mat_t m;
    for (int i = 0; i < A; i++)
      for (int k = 0; k < B; k++)
        m[i][k] = N'($urandom);
    return m;
  endfunction

  function automatic mat_t diag_mat(input int v);
    mat_t m;
    m = '0;
    for (int i = 0; i < A; i++) m[i][i] = N'(v);
    return m;
  endfunction

  // Raise start once the DUT is idle; return cycles until done is seen.
  task automatic start_and_wait(output int cyc);
    int g;
    g = 0;
    @(negedge clk);
    while ((busy || done) && g < 1000) begin
      @(negedge clk);
      g++;
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    start  = 1'b0;
    matrix = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got=%b exp=0", done);
    end
    for (int i = 0; i < A; i++)
      for (int j = 0; j < A; j++) begin
        checks++;
        if (cov[i][j] !== '0) begin
          errors++;
          $display("FAIL reset_cov[%0d][%0d] got=%h exp=0", i, j, cov[i][j]);
        end
      end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_identity();
    int cyc;
    logic [N-1:0] e;
    matrix = diag_mat(4);
    push_expected(matrix);
    start_and_wait(cyc);
    checks++;
    if (cyc !== 325 || done !== 1'b1) begin
      errors++;
      $display("FAIL ident_latency got=%0d done=%b exp=325", cyc, done);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ident_busy_at_done got=%b exp=0", busy);
    end
    for (int i = 0; i < A; i++)
      for (int j = 0; j < A; j++) begin
        e = exp_q.pop_front();
        checks++;
        if (cov[i][j] !== e) begin
          errors++;
          $display("FAIL ident_cov[%0d][%0d] got=%h exp=%h", i, j, cov[i][j], e);
        end
      end
  endtask

  task automatic test_random(input int runs);
    int cyc;
    logic [N-1:0] e;
    for (int r = 0; r < runs; r++) begin
      matrix = rand_mat();
      push_expected(matrix);
      start_and_wait(cyc);
      checks++;
      if (done !== 1'b1) begin
        errors++;
        $display("FAIL rand_timeout run=%0d cyc=%0d", r, cyc);
      end
      for (int i = 0; i < A; i++)
        for (int j = 0; j < A; j++) begin
          e = exp_q.pop_front();
          checks++;
          if (cov[i][j] !== e) begin
            errors++;
            $display("FAIL rand_cov[%0d][%0d] got=%h exp=%h", i, j, cov[i][j], e);
          end
          checks++;
          if (cov[i][j] !== cov[j][i]) begin
            errors++;
            $display("FAIL rand_sym[%0d][%0d] got=%h exp=%h", i, j, cov[i][j], cov[j][i]);
          end
        end
    end
  endtask

  task automatic test_max();
    int cyc;
    logic [N-1:0] e;
    for (int i = 0; i < A; i++)
      for (int k = 0; k < B; k++)
        matrix[i][k] = N'((1 << (N - 1)) - 1);
    push_expected(matrix);
    start_and_wait(cyc);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL max_timeout cyc=%0d", cyc);
    end
    for (int i = 0; i < A; i++)
      for (int j = 0; j < A; j++) begin
        e = exp_q.pop_front();
        checks++;
        if (cov[i][j] !== e) begin
          errors++;
          $display("FAIL max_cov[%0d][%0d] got=%h exp=%h", i, j, cov[i][j], e);
        end
      end
  endtask

  task automatic test_ignored_start();
    int n_done;
    logic [N-1:0] e;
    matrix = rand_mat();
    push_expected(matrix);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    n_done = 0;
    for (int cyc = 2; cyc <= 700; cyc++) begin
      @(posedge clk);
      #1;
      start = (cyc == 10) || (cyc == 100);
      if (cyc == 50) matrix = rand_mat();
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          for (int i = 0; i < A; i++)
            for (int j = 0; j < A; j++) begin
              e = exp_q.pop_front();
              checks++;
              if (cov[i][j] !== e) begin
                errors++;
                $display("FAIL ign_cov[%0d][%0d] got=%h exp=%h", i, j, cov[i][j], e);
              end
            end
        end
      end
    end
    start = 1'b0;
    checks++;
    if (n_done !== 1) begin
      errors++;
      $display("FAIL ign_done_count got=%0d exp=1", n_done);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [N-1:0] e;
    matrix = diag_mat(8);
    push_expected(matrix);
    start_and_wait(cyc);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL b2b_start_in_done got=%b exp=0", busy);
      end
    end
    for (int i = 0; i < A; i++)
      for (int j = 0; j < A; j++) begin
        e = exp_q.pop_front();
        checks++;
        if (cov[i][j] !== e) begin
          errors++;
          $display("FAIL b2b_cov[%0d][%0d] got=%h exp=%h", i, j, cov[i][j], e);
        end
      end
    matrix = rand_mat();
    push_expected(matrix);
    start_and_wait(cyc);
    checks++;
    if (cyc !== 325) begin
      errors++;
      $display("FAIL b2b_latency got=%0d exp=325", cyc);
    end
    for (int i = 0; i < A; i++)
      for (int j = 0; j < A; j++) begin
        e = exp_q.pop_front();
        checks++;
        if (cov[i][j] !== e) begin
          errors++;
          $display("FAIL b2b2_cov[%0d][%0d] got=%h exp=%h", i, j, cov[i][j], e);
        end
      end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [N-1:0] e;
    matrix = rand_mat();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (149) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_flags got=%b%b exp=00", busy, done);
    end
    for (int i = 0; i < A; i++)
      for (int j = 0; j < A; j++) begin
        checks++;
        if (cov[i][j] !== '0) begin
          errors++;
          $display("FAIL mid_reset_cov[%0d][%0d] got=%h exp=0", i, j, cov[i][j]);
        end
      end
    @(negedge clk);
    reset  = 1'b0;
    matrix = diag_mat(-4);
    push_expected(matrix);
    start_and_wait(cyc);
    checks++;
    if (cyc !== 325) begin
      errors++;
      $display("FAIL mid_latency got=%0d exp=325", cyc);
    end
    for (int i = 0; i < A; i++)
      for (int j = 0; j < A; j++) begin
        e = exp_q.pop_front();
        checks++;
        if (cov[i][j] !== e) begin
          errors++;
          $display("FAIL mid_cov[%0d][%0d] got=%h exp=%h", i, j, cov[i][j], e);
        end
      end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_random(2);
    test_max();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
